// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM tile-ROM read port between three
// level-handshake requesters; one outstanding read at a time.
module tile_rom_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        valid,
    output logic [DATA_W-1:0] data,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    input  logic [DATA_W-1:0] sdr_data,
    input  logic              sdr_valid,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req[n] and addr<n> level until it sees a
    // one-cycle valid[n]; the SDRAM side holds sdr_req/sdr_addr until a
    // single-cycle sdr_valid, whose sdr_data is captured in that same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        grant;
    logic [1:0]        ptr;
    logic [1:0]        c0, c1, c2, pick;
    logic [3:0]        req_ext;
    logic [2:0]        grant_onehot;
    logic [ADDR_W-1:0] pick_addr;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Scan ptr, ptr+1, ptr+2 (mod 3); the first set request wins.
    always_comb begin
        req_ext      = {1'b0, req};
        c0           = ptr;
        c1           = next_idx(c0);
        c2           = next_idx(c1);
        grant_onehot = 3'b001 << grant;
        if (req_ext[c0])
            pick = c0;
        else if (req_ext[c1])
            pick = c1;
        else
            pick = c2;
        case (pick)
            2'd0:    pick_addr = addr0;
            2'd1:    pick_addr = addr1;
            default: pick_addr = addr2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 2'd0;
            ptr      <= 2'd0;
            valid    <= 3'b000;
            data     <= '0;
            sdr_req  <= 1'b0;
            sdr_addr <= '0;
        end else begin
            valid <= 3'b000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= pick;
                        sdr_addr <= pick_addr;
                        sdr_req  <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (sdr_valid) begin
                        data    <= sdr_data;
                        // A requester that dropped req mid-read gets no pulse.
                        valid   <= req_ext[grant] ? grant_onehot : 3'b000;
                        sdr_req <= 1'b0;
                        ptr     <= next_idx(grant);
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed bench for tile_rom_arbiter: reset, single read, round-robin,
// pointer fairness, abort, reset mid-read and back-to-back reads.
module tb_tile_rom_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        req = 3'b000;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [ADDR_W-1:0] addr2 = '0;
    logic [2:0]        valid;
    logic [DATA_W-1:0] data;
    logic              sdr_req;
    logic [ADDR_W-1:0] sdr_addr;
    logic [DATA_W-1:0] sdr_data = '0;
    logic              sdr_valid = 1'b0;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    tile_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .valid     (valid),
        .data      (data),
        .sdr_req   (sdr_req),
        .sdr_addr  (sdr_addr),
        .sdr_data  (sdr_data),
        .sdr_valid (sdr_valid),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 3'b000;
        sdr_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_sdr(input logic [DATA_W-1:0] d);
        sdr_valid = 1'b1;
        sdr_data  = d;
        step();
        sdr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", valid); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_sdr_req got %b exp 0", sdr_req); end
        checks++; if (sdr_addr !== 18'h0) begin errors++; $display("FAIL reset_sdr_addr got %h exp 0", sdr_addr); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_single();
        do_reset();
        addr0 = 18'h00123;
        req   = 3'b001;
        step();
        checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL single_sdr_req got %b exp 1", sdr_req); end
        checks++; if (sdr_addr !== 18'h00123) begin errors++; $display("FAIL single_sdr_addr got %h exp 00123", sdr_addr); end
        addr0 = 18'h3ffff;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (sdr_req !== 1'b1 || sdr_addr !== 18'h00123 || valid !== 3'b000) begin
                errors++; $display("FAIL single_hold cyc %0d got req %b addr %h valid %b exp 1 00123 000", i, sdr_req, sdr_addr, valid);
            end
        end
        pulse_sdr(32'hDEADBEEF);
        checks++; if (valid !== 3'b001) begin errors++; $display("FAIL single_valid got %b exp 001", valid); end
        checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", data); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL single_sdr_req_drop got %b exp 0", sdr_req); end
        req = 3'b000;
        step();
        checks++; if (valid !== 3'b000) begin errors++; $display("FAIL single_valid_one_cycle got %b exp 000", valid); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL single_back_idle got %0d exp 0", dbg_state); end
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_addr [4];
        logic [2:0]        exp_valid [4];
        exp_addr  = '{18'h00010, 18'h00020, 18'h00030, 18'h00010};
        exp_valid = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        addr0 = 18'h00010;
        addr1 = 18'h00020;
        addr2 = 18'h00030;
        req   = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (sdr_addr !== exp_addr[k]) begin errors++; $display("FAIL rr_addr %0d got %h exp %h", k, sdr_addr, exp_addr[k]); end
            step();
            step();
            pulse_sdr(32'hA000_0000 + DATA_W'(k));
            checks++; if (valid !== exp_valid[k] || data !== 32'hA000_0000 + DATA_W'(k)) begin
                errors++; $display("FAIL rr_valid %0d got %b %h exp %b %h", k, valid, data, exp_valid[k], 32'hA000_0000 + DATA_W'(k));
            end
            step();
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_fairness();
        do_reset();
        addr0 = 18'h00010;
        addr1 = 18'h00020;
        req   = 3'b010;
        step();
        checks++; if (sdr_addr !== 18'h00020) begin errors++; $display("FAIL fair_first_addr got %h exp 00020", sdr_addr); end
        pulse_sdr(32'h1111_0001);
        checks++; if (valid !== 3'b010) begin errors++; $display("FAIL fair_first_valid got %b exp 010", valid); end
        req = 3'b011;
        step();
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL fair_no_grant_in_done got %b exp 0", sdr_req); end
        step();
        checks++; if (sdr_addr !== 18'h00010) begin errors++; $display("FAIL fair_ptr2_addr got %h exp 00010", sdr_addr); end
        pulse_sdr(32'h1111_0002);
        checks++; if (valid !== 3'b001) begin errors++; $display("FAIL fair_second_valid got %b exp 001", valid); end
        req = 3'b000;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        addr1 = 18'h00020;
        addr2 = 18'h00030;
        req   = 3'b100;
        step();
        checks++; if (sdr_addr !== 18'h00030) begin errors++; $display("FAIL abort_addr got %h exp 00030", sdr_addr); end
        step();
        step();
        req = 3'b010;
        step();
        checks++; if (sdr_req !== 1'b1 || sdr_addr !== 18'h00030) begin
            errors++; $display("FAIL abort_hold got req %b addr %h exp 1 00030", sdr_req, sdr_addr);
        end
        pulse_sdr(32'h2222_0000);
        checks++; if (valid !== 3'b000) begin errors++; $display("FAIL abort_no_valid got %b exp 000", valid); end
        checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL abort_sdr_req got %b exp 0", sdr_req); end
        step();
        step();
        checks++; if (sdr_req !== 1'b1 || sdr_addr !== 18'h00020) begin
            errors++; $display("FAIL abort_next_grant got req %b addr %h exp 1 00020", sdr_req, sdr_addr);
        end
        pulse_sdr(32'h2222_0001);
        checks++; if (valid !== 3'b010 || data !== 32'h2222_0001) begin
            errors++; $display("FAIL abort_next_valid got %b %h exp 010 22220001", valid, data);
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        addr0 = 18'h00010;
        addr1 = 18'h00020;
        req   = 3'b001;
        step();
        pulse_sdr(32'h3333_0000);
        req = 3'b010;
        step();
        step();
        checks++; if (sdr_addr !== 18'h00020 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL rmid_busy got addr %h state %0d exp 00020 1", sdr_addr, dbg_state);
        end
        step();
        reset = 1'b1;
        req   = 3'b000;
        step();
        reset = 1'b0;
        checks++; if (valid !== 3'b000 || data !== 32'h0 || sdr_req !== 1'b0 || sdr_addr !== 18'h0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL rmid_outputs got %b %h %b %h %0d exp all 0", valid, data, sdr_req, sdr_addr, dbg_state);
        end
        step();
        step();
        pulse_sdr(32'h3333_BAD0);
        checks++; if (valid !== 3'b000 || data !== 32'h0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL rmid_stray got valid %b data %h state %0d exp 000 0 0", valid, data, dbg_state);
        end
        req = 3'b011;
        step();
        checks++; if (sdr_req !== 1'b1 || sdr_addr !== 18'h00010) begin
            errors++; $display("FAIL rmid_ptr0 got req %b addr %h exp 1 00010", sdr_req, sdr_addr);
        end
        pulse_sdr(32'h3333_0001);
        checks++; if (valid !== 3'b001 || data !== 32'h3333_0001) begin
            errors++; $display("FAIL rmid_valid got %b %h exp 001 33330001", valid, data);
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_back_to_back();
        logic              pend;
        logic [DATA_W-1:0] pend_d;
        logic              prev_req;
        logic              seen_high;
        int                low_run;
        int                n_pulse;
        int                n_drive;
        logic [2:0]        exp_v;
        do_reset();
        addr0 = 18'h00010;
        addr1 = 18'h00020;
        addr2 = 18'h00030;
        req       = 3'b111;
        pend      = 1'b0;
        pend_d    = '0;
        prev_req  = 1'b0;
        seen_high = 1'b0;
        low_run   = 0;
        n_pulse   = 0;
        n_drive   = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (pend) begin
                exp_v = 3'b001 << (n_pulse % 3);
                checks++; if (valid !== exp_v || data !== pend_d) begin
                    errors++; $display("FAIL b2b_valid cyc %0d got %b %h exp %b %h", c, valid, data, exp_v, pend_d);
                end
                n_pulse++;
            end else begin
                checks++; if (valid !== 3'b000) begin errors++; $display("FAIL b2b_idle_valid cyc %0d got %b exp 000", c, valid); end
            end
            if (sdr_req && !prev_req && seen_high) begin
                checks++; if (low_run < 2) begin errors++; $display("FAIL b2b_gap cyc %0d got %0d exp >=2", c, low_run); end
            end
            if (sdr_req) begin
                seen_high = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
            end
            prev_req = sdr_req;
            // SDRAM model answers in the first cycle it sees a request.
            pend = sdr_req;
            if (sdr_req) begin
                pend_d = 32'hB000_0000 + DATA_W'(n_drive);
                n_drive++;
            end
            sdr_valid = sdr_req;
            sdr_data  = pend_d;
        end
        sdr_valid = 1'b0;
        req = 3'b000;
        step();
        checks++; if (n_pulse < 8) begin errors++; $display("FAIL b2b_count got %0d exp >=8", n_pulse); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
